// File: rtl/greenflow_power_ramp.sv
`default_nettype none
// ============================================================================
// greenflow_power_ramp : slew-limited charger setpoint with fault shutdown,
// cooldown holdoff and valid/ready command delivery.
// Optional charger watchdog: define GREENFLOW_RAMP_WDOG_EN.
// Revision: 1.0
// ============================================================================
module greenflow_power_ramp #(
    parameter logic [15:0] RAMP_STEP     = 16'd5,
    parameter logic [15:0] TICK_DIV      = 16'd1000,
    parameter logic [7:0]  HOLDOFF_TICKS = 8'd8,
    parameter logic [15:0] WDOG_CYCLES   = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] gate_power_kw,
    input  logic [1:0]  gate_status,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_kw,
    output logic [15:0] setpoint_kw,
    output logic [1:0]  ramp_state,
    output logic [7:0]  fault_count,
    output logic        cmd_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RAMP     = 2'b01,
        ST_HOLD     = 2'b10,
        ST_SHUTDOWN = 2'b11
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_presc, w_presc_next;
    logic [7:0]  r_holdoff, w_holdoff_next;
    logic [15:0] r_setpoint, w_sp_next;
    logic [15:0] r_cmd_kw, w_kw_next;
    logic        r_cmd_valid, w_valid_next;
    logic [15:0] r_last_acc, w_acc_next;
    logic [7:0]  r_fault_count, w_count_next;
    logic        r_fault_q;

    logic        w_tick, w_fault, w_entry, w_shut, w_xfer;
    logic        w_wdog_trip, w_timeout;
    logic [15:0] w_diff, w_step, w_sp_inc, w_issue_val;
    logic [16:0] w_sum;

    assign w_tick  = (r_presc == TICK_DIV - 16'd1);
    assign w_fault = gate_status[1];
    assign w_entry = (w_fault & ~r_fault_q) | w_wdog_trip;
    assign w_shut  = w_fault | w_wdog_trip | w_timeout;
    assign w_xfer  = r_cmd_valid & cmd_ready;

    // Step is clipped to the remaining distance so the ramp never overshoots.
    assign w_diff   = gate_power_kw - r_setpoint;
    assign w_step   = (w_diff < RAMP_STEP) ? w_diff : RAMP_STEP;
    assign w_sum    = {1'b0, r_setpoint} + {1'b0, w_step};
    assign w_sp_inc = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = w_tick ? 16'd0 : r_presc + 16'd1;
        w_holdoff_next = r_holdoff;
        w_sp_next      = r_setpoint;
        w_kw_next      = r_cmd_kw;
        w_valid_next   = r_cmd_valid;
        w_acc_next     = w_xfer ? r_cmd_kw : r_last_acc;
        w_count_next   = r_fault_count;
        w_issue_val    = r_setpoint;

        if (w_shut) begin
            w_sp_next      = 16'd0;
            w_state_next   = ST_SHUTDOWN;
            w_holdoff_next = HOLDOFF_TICKS;
        end else if (r_state == ST_SHUTDOWN) begin
            w_sp_next = 16'd0;
            if (r_holdoff == 8'd0)
                w_state_next = ST_IDLE;
            else if (w_tick)
                w_holdoff_next = r_holdoff - 8'd1;
        end else begin
            if (gate_power_kw < r_setpoint)
                w_sp_next = gate_power_kw;
            else if ((gate_power_kw > r_setpoint) && w_tick && !r_cmd_valid)
                w_sp_next = w_sp_inc;

            if ((w_sp_next == 16'd0) && (gate_power_kw == 16'd0))
                w_state_next = ST_IDLE;
            else if (w_sp_next < gate_power_kw)
                w_state_next = ST_RAMP;
            else
                w_state_next = ST_HOLD;
        end

        // A simultaneous decrease is issued directly so a stale higher value never goes out.
        if (w_sp_next < r_setpoint)
            w_issue_val = w_sp_next;

        if (w_entry) begin
            w_valid_next = 1'b1;
            w_kw_next    = 16'd0;
        end else if (r_cmd_valid && !cmd_ready) begin
            if (w_sp_next < r_cmd_kw)
                w_kw_next = w_sp_next;
        end else if (w_issue_val != w_acc_next) begin
            w_valid_next = 1'b1;
            w_kw_next    = w_issue_val;
        end else begin
            w_valid_next = 1'b0;
        end

        if (w_entry && (r_fault_count != 8'hFF))
            w_count_next = r_fault_count + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_presc       <= 16'd0;
            r_holdoff     <= 8'd0;
            r_setpoint    <= 16'd0;
            r_cmd_kw      <= 16'd0;
            r_cmd_valid   <= 1'b0;
            r_last_acc    <= 16'd0;
            r_fault_count <= 8'd0;
            r_fault_q     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_presc       <= w_presc_next;
            r_holdoff     <= w_holdoff_next;
            r_setpoint    <= w_sp_next;
            r_cmd_kw      <= w_kw_next;
            r_cmd_valid   <= w_valid_next;
            r_last_acc    <= w_acc_next;
            r_fault_count <= w_count_next;
            r_fault_q     <= w_fault;
        end
    end

`ifdef GREENFLOW_RAMP_WDOG_EN
    logic [15:0] r_wdog;
    logic        r_timeout;

    assign w_wdog_trip = r_cmd_valid & ~cmd_ready & ~r_timeout &
                         (r_wdog == WDOG_CYCLES - 16'd1);
    assign w_timeout   = r_timeout;
    assign cmd_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog    <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_cmd_valid && !cmd_ready && !r_timeout)
                r_wdog <= r_wdog + 16'd1;
            else
                r_wdog <= 16'd0;
            if (w_wdog_trip)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_wdog_trip = 1'b0;
    assign w_timeout   = 1'b0;
    assign cmd_timeout = 1'b0 & (|WDOG_CYCLES);
`endif

    assign cmd_valid   = r_cmd_valid;
    assign cmd_kw      = r_cmd_kw;
    assign setpoint_kw = r_setpoint;
    assign ramp_state  = r_state;
    assign fault_count = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_greenflow_power_ramp.sv
`default_nettype none
// ============================================================================
// tb_greenflow_power_ramp : directed table-driven bench for the power ramp.
// Revision: 1.0
// ============================================================================
module tb_greenflow_power_ramp;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RAMP = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_SHUT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gate_power_kw = 16'd0;
    logic [1:0]  gate_status = 2'b00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [15:0] cmd_kw;
    logic [15:0] setpoint_kw;
    logic [1:0]  ramp_state;
    logic [7:0]  fault_count;
    logic        cmd_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic last_tick = 1'b0;

    greenflow_power_ramp #(
        .RAMP_STEP    (16'd5),
        .TICK_DIV     (16'd4),
        .HOLDOFF_TICKS(8'd8),
        .WDOG_CYCLES  (16'd16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate_power_kw(gate_power_kw),
        .gate_status  (gate_status),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kw       (cmd_kw),
        .setpoint_kw  (setpoint_kw),
        .ramp_state   (ramp_state),
        .fault_count  (fault_count),
        .cmd_timeout  (cmd_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pw;
        logic [15:0] e_sp;
        logic        e_v;
        logic [15:0] e_kw;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] pw, input logic [15:0] sp, input logic v,
                       input logic [15:0] kw, input logic [1:0] st);
        vec_t r;
        r.pw = pw; r.e_sp = sp; r.e_v = v; r.e_kw = kw; r.e_st = st;
        tbl.push_back(r);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bench-side prescaler model: tick on edges whose index mod 4 is 3.
    task automatic step();
        last_tick = ((cyc % 4) == 3);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (ramp_state == st) ok = 1'b1;
        end
    endtask

    task automatic wait_sp(input logic [15:0] sp, input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (setpoint_kw == sp) ok = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int   n_ticks;
        logic early;

        // Ramp 0->23 in 5 kW steps, then an immediate drop to 8.
        for (int i = 0; i < 3; i++) add(16'd23, 16'd0, 1'b0, 16'd0, S_RAMP);
        add(16'd23, 16'd5, 1'b0, 16'd0, S_RAMP);
        add(16'd23, 16'd5, 1'b1, 16'd5, S_RAMP);
        for (int i = 0; i < 2; i++) add(16'd23, 16'd5, 1'b0, 16'd5, S_RAMP);
        add(16'd23, 16'd10, 1'b0, 16'd5, S_RAMP);
        add(16'd23, 16'd10, 1'b1, 16'd10, S_RAMP);
        for (int i = 0; i < 2; i++) add(16'd23, 16'd10, 1'b0, 16'd10, S_RAMP);
        add(16'd23, 16'd15, 1'b0, 16'd10, S_RAMP);
        add(16'd23, 16'd15, 1'b1, 16'd15, S_RAMP);
        for (int i = 0; i < 2; i++) add(16'd23, 16'd15, 1'b0, 16'd15, S_RAMP);
        add(16'd23, 16'd20, 1'b0, 16'd15, S_RAMP);
        add(16'd23, 16'd20, 1'b1, 16'd20, S_RAMP);
        for (int i = 0; i < 2; i++) add(16'd23, 16'd20, 1'b0, 16'd20, S_RAMP);
        add(16'd23, 16'd23, 1'b0, 16'd20, S_HOLD);
        add(16'd23, 16'd23, 1'b1, 16'd23, S_HOLD);
        add(16'd23, 16'd23, 1'b0, 16'd23, S_HOLD);
        add(16'd8,  16'd8,  1'b1, 16'd8,  S_HOLD);
        add(16'd8,  16'd8,  1'b0, 16'd8,  S_HOLD);
        add(16'd8,  16'd8,  1'b0, 16'd8,  S_HOLD);

        // Reset values, observed while reset is held.
        #12;
        check("rst_setpoint", setpoint_kw, 16'd0);
        check("rst_cmd_kw", cmd_kw, 16'd0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_state", ramp_state, S_IDLE);
        check("rst_fault_count", fault_count, 8'd0);
        check("rst_timeout", cmd_timeout, 1'b0);

        gate_power_kw = 16'd23; gate_status = 2'b00; cmd_ready = 1'b1;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            gate_power_kw = tbl[i].pw;
            step();
            check($sformatf("vec%0d_setpoint", i), setpoint_kw, tbl[i].e_sp);
            check($sformatf("vec%0d_cmd_valid", i), cmd_valid, tbl[i].e_v);
            check($sformatf("vec%0d_cmd_kw", i), cmd_kw, tbl[i].e_kw);
            check($sformatf("vec%0d_state", i), ramp_state, tbl[i].e_st);
        end
        check("vec_fault_count", fault_count, 8'd0);
        check("vec_timeout", cmd_timeout, 1'b0);

        // Thermal trip while ramping at 15 kW, then holdoff and re-ramp.
        gate_power_kw = 16'd40; gate_status = 2'b00; cmd_ready = 1'b1;
        do_reset();
        wait_sp(16'd15, 40, ok);
        check("trip_reach15", ok, 1'b1);
        gate_status = 2'b10;
        step();
        check("trip_setpoint", setpoint_kw, 16'd0);
        check("trip_state", ramp_state, S_SHUT);
        check("trip_count", fault_count, 8'd1);
        check("trip_cmd_valid", cmd_valid, 1'b1);
        check("trip_cmd_kw", cmd_kw, 16'd0);
        step();
        step();
        gate_status = 2'b00;
        n_ticks = 0;
        early = 1'b0;
        for (int k = 0; k < 60 && n_ticks < 8; k++) begin
            step();
            if (last_tick) n_ticks++;
            if (ramp_state != S_SHUT) early = 1'b1;
        end
        check("holdoff_no_early_exit", early, 1'b0);
        check("holdoff_ticks_seen", n_ticks, 8);
        check("holdoff_last_tick_state", ramp_state, S_SHUT);
        step();
        check("holdoff_exit_idle", ramp_state, S_IDLE);
        check("holdoff_exit_setpoint", setpoint_kw, 16'd0);
        step();
        check("rearm_state_ramp", ramp_state, S_RAMP);
        wait_sp(16'd5, 8, ok);
        check("rearm_first_step", ok, 1'b1);

        // AI fault overrides a stalled pending command.
        gate_power_kw = 16'd40; gate_status = 2'b00; cmd_ready = 1'b1;
        do_reset();
        wait_sp(16'd10, 40, ok);
        check("stall_reach10", ok, 1'b1);
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("stall_cmd_valid", cmd_valid, 1'b1);
        check("stall_cmd_kw", cmd_kw, 16'd10);
        check("stall_no_ramp", setpoint_kw, 16'd10);
        gate_status = 2'b11;
        step();
        check("ai_cmd_kw", cmd_kw, 16'd0);
        check("ai_cmd_valid", cmd_valid, 1'b1);
        check("ai_setpoint", setpoint_kw, 16'd0);
        check("ai_state", ramp_state, S_SHUT);
        gate_status = 2'b00; cmd_ready = 1'b1;
        step();
        check("ai_xfer_done", cmd_valid, 1'b0);
        check("ai_xfer_kw", cmd_kw, 16'd0);

        // Asynchronous reset abandons a pending command.
        gate_power_kw = 16'd40; cmd_ready = 1'b0;
        do_reset();
        wait_sp(16'd5, 10, ok);
        step();
        check("areset_pending", cmd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_cmd_valid", cmd_valid, 1'b0);
        check("areset_cmd_kw", cmd_kw, 16'd0);
        check("areset_setpoint", setpoint_kw, 16'd0);

        // Fault counting: re-entry inside SHUTDOWN, then saturation.
        gate_power_kw = 16'd0; gate_status = 2'b00; cmd_ready = 1'b1;
        do_reset();
        gate_status = 2'b10; step();
        gate_status = 2'b00; step();
        gate_status = 2'b10; step();
        check("reentry_count", fault_count, 8'd2);
        gate_status = 2'b00;
        wait_state(S_IDLE, 60, ok);
        check("reentry_idle", ok, 1'b1);
        for (int p = 0; p < 298; p++) begin
            gate_status = 2'b10; step();
            gate_status = 2'b00;
            wait_state(S_IDLE, 60, ok);
            if (!ok) begin
                check("sat_wait_idle", ok, 1'b1);
                break;
            end
        end
        check("sat_count", fault_count, 8'd255);
        check("sat_timeout", cmd_timeout, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
